// File: rtl/next_pc_unit_pkg.sv
// Shared types and constants for the next-PC unit: FSM state encoding,
// default address width and the alignment-bit helper.
package next_pc_unit_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } pc_state_e;

  // Number of low address bits that must be zero for a legal fetch target.
  function automatic int unsigned align_bits(input int unsigned inst_align);
    return (inst_align == 2) ? 1 : 2;
  endfunction

endpackage

// File: rtl/next_pc_unit_adder.sv
// Plain modulo-2^OPERAND_WIDTH adder used as the sequential PC incrementer.
module next_pc_unit_adder #(
  parameter int unsigned OPERAND_WIDTH = 32
) (
  input  logic [OPERAND_WIDTH-1:0] i_op1,
  input  logic [OPERAND_WIDTH-1:0] i_op2,
  output logic [OPERAND_WIDTH-1:0] o_sum
);

  assign o_sum = i_op1 + i_op2;

endmodule

// File: rtl/next_pc_unit.sv
// Fetch-address generator: HOLD/RUN FSM, redirect with alignment check,
// stall and sequential increment. Optional trap path under NEXT_PC_TRAP_EN.
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter int unsigned      XLEN              = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_VECTOR      = '0,
  parameter int unsigned      INST_ALIGN        = 4,
  parameter int unsigned      RESET_HOLD_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
`ifdef NEXT_PC_TRAP_EN
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] epc,
`endif
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_valid,
  output logic            misalign_err
);

  localparam int unsigned     ALIGN_BITS = align_bits(INST_ALIGN);
  localparam logic [XLEN-1:0] INC        = XLEN'(INST_ALIGN);
  localparam logic [3:0]      HOLD_LAST  = 4'(RESET_HOLD_CYCLES - 1);

  pc_state_e       r_state;
  logic [3:0]      r_hold_cnt;
  logic [XLEN-1:0] r_pc;
  logic            r_pc_valid;
  logic            r_misalign;
  logic [XLEN-1:0] w_pc_inc;
  logic            w_misaligned;
  logic            w_trap;

  next_pc_unit_adder #(
    .OPERAND_WIDTH(XLEN)
  ) u_inc (
    .i_op1(r_pc),
    .i_op2(INC),
    .o_sum(w_pc_inc)
  );

  assign w_misaligned = |redirect_target[ALIGN_BITS-1:0];

`ifdef NEXT_PC_TRAP_EN
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] w_trap_target;

  assign w_trap        = trap_valid;
  assign w_trap_target = {trap_vector[XLEN-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
  assign epc           = r_epc;
`else
  assign w_trap = 1'b0;
`endif

  // Priority: trap > redirect (misaligned target holds pc) > stall > sequential.
  always_comb begin
    pc_next = r_pc;
    if (r_state == ST_HOLD) begin
      pc_next = RESET_VECTOR;
    end
`ifdef NEXT_PC_TRAP_EN
    else if (trap_valid) begin
      pc_next = w_trap_target;
    end
`endif
    else if (redirect_valid) begin
      pc_next = w_misaligned ? r_pc : redirect_target;
    end else if (!stall) begin
      pc_next = w_pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_HOLD;
      r_hold_cnt <= 4'd0;
      r_pc       <= RESET_VECTOR;
      r_pc_valid <= 1'b0;
      r_misalign <= 1'b0;
`ifdef NEXT_PC_TRAP_EN
      r_epc      <= '0;
`endif
    end else if (r_state == ST_HOLD) begin
      // pc already sits at RESET_VECTOR, so leaving HOLD fetches it exactly once.
      r_misalign <= 1'b0;
      if (r_hold_cnt == HOLD_LAST) begin
        r_state    <= ST_RUN;
        r_pc_valid <= 1'b1;
      end else begin
        r_hold_cnt <= r_hold_cnt + 4'd1;
      end
    end else begin
      r_pc       <= pc_next;
      r_misalign <= redirect_valid & w_misaligned & ~w_trap;
`ifdef NEXT_PC_TRAP_EN
      if (trap_valid) begin
        r_epc <= r_pc;
      end
`endif
    end
  end

  assign pc           = r_pc;
  assign pc_valid     = r_pc_valid;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed scenarios plus randomized
// traffic checked against a behavioural next-PC model.
module tb_next_pc_unit;

  localparam logic [31:0] RV = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        pc_valid;
  logic        misalign_err;
`ifdef NEXT_PC_TRAP_EN
  logic        trap_valid = 1'b0;
  logic [31:0] trap_vector = 32'h0;
  logic [31:0] epc;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_valid;
  logic        m_err;
  logic        m_run;
  int          m_hold_left;

  next_pc_unit #(
    .XLEN(32),
    .RESET_VECTOR(RV),
    .INST_ALIGN(4),
    .RESET_HOLD_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
`ifdef NEXT_PC_TRAP_EN
    .trap_valid(trap_valid),
    .trap_vector(trap_vector),
    .epc(epc),
`endif
    .pc(pc),
    .pc_next(pc_next),
    .pc_valid(pc_valid),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc        = RV;
    m_epc       = 32'h0;
    m_valid     = 1'b0;
    m_err       = 1'b0;
    m_run       = 1'b0;
    m_hold_left = 1;
  endtask

  function automatic logic [31:0] model_next();
    if (!rst || !m_run) return RV;
`ifdef NEXT_PC_TRAP_EN
    if (trap_valid) return trap_vector & ~32'd3;
`endif
    if (redirect_valid) return ((redirect_target % 4) == 0) ? redirect_target : m_pc;
    if (stall) return m_pc;
    return m_pc + 32'd4;
  endfunction

  task automatic check_outputs();
    chk("pc", pc, m_pc);
    chk("pc_valid", {31'h0, pc_valid}, {31'h0, m_valid});
    chk("misalign_err", {31'h0, misalign_err}, {31'h0, m_err});
`ifdef NEXT_PC_TRAP_EN
    chk("epc", epc, m_epc);
`endif
  endtask

  // Inputs are already applied; check pc_next, advance one edge, check state.
  task automatic step();
    logic [31:0] nxt;
    logic        trap;
    #1;
    nxt = model_next();
    chk("pc_next", pc_next, nxt);
    trap = 1'b0;
`ifdef NEXT_PC_TRAP_EN
    trap = trap_valid;
`endif
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else if (!m_run) begin
      m_err = 1'b0;
      m_hold_left--;
      if (m_hold_left == 0) begin
        m_run   = 1'b1;
        m_valid = 1'b1;
      end
    end else begin
      m_err = redirect_valid && !trap && ((redirect_target % 4) != 0);
      if (trap) m_epc = m_pc;
      m_pc = nxt;
    end
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic s, input logic rv, input logic [31:0] tgt);
    stall           = s;
    redirect_valid  = rv;
    redirect_target = tgt;
  endtask

  initial begin
    model_reset();
    // Reset held for three cycles, then released mid-cycle.
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("hold_valid", {31'h0, pc_valid}, 32'h0);
    step();
    chk("first_pc", pc, 32'h0000_1000);
    step();
    step();
    chk("third_pc", pc, 32'h0000_1008);

    // Stall holds, redirect beats stall.
    drive(1'b0, 1'b1, 32'h20); step();
    drive(1'b1, 1'b0, 32'h0);  step(); step();
    chk("stall_hold", pc, 32'h20);
    drive(1'b1, 1'b1, 32'h80); step();
    chk("flush_beats_stall", pc, 32'h80);

    // Misaligned redirect is rejected.
    drive(1'b0, 1'b1, 32'h40); step();
    drive(1'b0, 1'b1, 32'h82); step();
    chk("misalign_hold", pc, 32'h40);
    chk("misalign_pulse", {31'h0, misalign_err}, 32'h1);
    drive(1'b0, 1'b0, 32'h0);  step();
    chk("misalign_next", pc, 32'h44);
    chk("misalign_clear", {31'h0, misalign_err}, 32'h0);

    // Wrap-around of the sequential increment.
    drive(1'b0, 1'b1, 32'hFFFF_FFF8); step();
    drive(1'b0, 1'b0, 32'h0); step(); step();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_valid", {31'h0, pc_valid}, 32'h1);

`ifdef NEXT_PC_TRAP_EN
    drive(1'b0, 1'b1, 32'h100); step();
    trap_valid  = 1'b1;
    trap_vector = 32'h303;
    drive(1'b1, 1'b1, 32'h200); step();
    chk("trap_pc", pc, 32'h300);
    chk("trap_epc", epc, 32'h100);
    trap_valid = 1'b0;
    drive(1'b0, 1'b0, 32'h0); step();
`endif

    // Asynchronous reset between edges.
    drive(1'b0, 1'b1, 32'h58); step();
    drive(1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_pc", pc, RV);
    chk("async_rst_valid", {31'h0, pc_valid}, 32'h0);
    model_reset();
    step(); step();
    rst = 1'b1;
    step();
    chk("rerun_pc", pc, RV);

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) != 0);
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'd3));
`ifdef NEXT_PC_TRAP_EN
      trap_valid  = ($urandom_range(0, 15) == 0);
      trap_vector = $urandom;
`endif
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, address width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have parameter INST_ALIGN, default 4, sequential increment and required target alignment in bytes (legal values 2 or 4).
REQ-004 SHALL have parameter RESET_HOLD_CYCLES, default 1, idle cycles after reset release before the first valid PC (legal range 1..15).
REQ-005 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset (asserts immediately, releases synchronously to clk).
REQ-007 SHALL have port stall, input, 1, hold current PC.
REQ-008 SHALL have port redirect_valid, input, 1, jump/branch taken this cycle.
REQ-009 SHALL have port redirect_target, input, XLEN, jump/branch destination.
REQ-010 SHALL have port pc, output, XLEN, registered current fetch address.
REQ-011 SHALL have port pc_next, output, XLEN, combinational value to be loaded at next edge.
REQ-012 SHALL have port pc_valid, output, 1, registered; pc is a real fetch address.
REQ-013 SHALL have port misalign_err, output, 1, registered one-cycle pulse on rejected redirect.

Function
REQ-014 SHALL implement a two-state FSM: HOLD and RUN.
REQ-015 In HOLD, SHALL keep pc=RESET_VECTOR and pc_valid=0, ignore all inputs, and count RESET_HOLD_CYCLES edges after reset release, then enter RUN.
REQ-016 On entering RUN, SHALL assert pc_valid with pc=RESET_VECTOR; the instruction at RESET_VECTOR is fetched exactly once.
REQ-017 In RUN, SHALL select the next PC with priority: trap (if compiled in) > redirect > stall > sequential.
REQ-018 Sequential: pc <= pc + INST_ALIGN modulo 2^XLEN; {XLEN{1'b1}} - INST_ALIGN + 1 wraps to 0.
REQ-019 Redirect SHALL override stall (flush beats stall); pc <= redirect_target on the same edge.
REQ-020 A redirect_target not a multiple of INST_ALIGN SHALL be rejected: pc holds, misalign_err=1 for exactly the following cycle.
REQ-021 Stall alone SHALL hold pc and keep pc_valid=1.
REQ-022 pc_next SHALL equal the value pc takes at the next edge under current inputs; in HOLD it SHALL equal RESET_VECTOR.
REQ-023 Once in RUN, pc_valid SHALL stay 1 until reset.

Reset
REQ-024 rst=0 SHALL immediately force pc=RESET_VECTOR, pc_valid=0, misalign_err=0, FSM=HOLD, hold counter=0, epc=0 (if present), including mid-operation.
REQ-025 HOLD counting SHALL start on the first rising edge with rst=1.

Configuration
REQ-026 Macro NEXT_PC_TRAP_EN SHALL, when defined, add ports trap_valid (in, 1), trap_vector (in, XLEN), epc (out, XLEN, registered).
REQ-027 With NEXT_PC_TRAP_EN: trap_valid in RUN SHALL load pc <= trap_vector with low log2(INST_ALIGN) bits forced to 0, and epc <= current pc on the same edge, overriding redirect, stall and misalign checks.
REQ-028 Without NEXT_PC_TRAP_EN: none of these ports or the epc register SHALL exist, and priority reduces to redirect > stall > sequential.

Structure
REQ-029 XLEN and the HOLD/RUN state encodings SHALL live in the shared Parameters.vh header.
REQ-030 The incrementer SHALL be one instance of the existing Adder sub-module (OPERAND_WIDTH=XLEN, op2=INST_ALIGN); the PC register SHALL be local, not the sync-reset Register.

Verification
REQ-031 Reset: rst low 3 cycles, release; RESET_VECTOR=32'h0000_1000, hold 1 -> pc_valid=0 one cycle, then pc 1000,1004,1008 with pc_valid=1.
REQ-032 Wrap: force sequential run to pc=32'hFFFF_FFFC -> next pc=0, pc_valid stays 1.
REQ-033 Stall+redirect: pc=0x20, stall=1 two cycles -> pc=0x20 held; stall=1 with redirect to 0x80 -> pc=0x80 next cycle.
REQ-034 Misalign: redirect_target=0x82 (INST_ALIGN=4) at pc=0x40 -> pc=0x40 held, misalign_err=1 one cycle, then pc=0x44.
REQ-035 Trap (NEXT_PC_TRAP_EN): pc=0x100, trap_valid with redirect to 0x200, trap_vector=0x303 -> pc=0x300, epc=0x100.
REQ-036 Mid-run reset: rst low asynchronously between edges at pc=0x58 -> pc=RESET_VECTOR, pc_valid=0 before next edge.
